// File: rtl/load_store_unit_if.sv
// Load/store unit bus bundle.
// Groups the pipeline request/response handshakes and the data-memory port.
//   Request : req_valid, req_ready, req_we, req_base, req_offset, req_wdata
//   Response: resp_valid, resp_ready, resp_data, resp_err
//   Memory  : mem_addr, mem_wdata, mem_read, mem_write, mem_rdata
// Modports:
//   slave  - the load/store unit itself
//   master - the pipeline plus data memory surrounding the unit
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_base;
    logic [15:0] req_offset;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;

    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_base, req_offset, req_wdata,
        output req_ready,
        output resp_valid, resp_data, resp_err,
        input  resp_ready,
        output mem_addr, mem_wdata, mem_read, mem_write,
        input  mem_rdata
    );

    modport master (
        output req_valid, req_we, req_base, req_offset, req_wdata,
        input  req_ready,
        input  resp_valid, resp_data, resp_err,
        output resp_ready,
        input  mem_addr, mem_wdata, mem_read, mem_write,
        output mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one load or store at a time, computes the
// effective address base + sext(offset), issues a single memory strobe
// and returns a response held until the consumer takes it.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - load_store_unit_if.slave (request, response, memory port)
//   busy   - high whenever the unit is not idle
// Optional feature: define LSU_ADDR_CHECK_EN to flag misaligned or
// out-of-range (beyond 1024 words) addresses as errors with no memory access.
// Latency from acceptance edge to resp_valid: load 3, store 2, error 1.
module load_store_unit (
    input  logic                  clk,
    input  logic                  rst_n,
    load_store_unit_if.slave      bus,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state, state_nx;

    logic        we_q;
    logic [9:0]  addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] ea;
    logic        addr_err;
    logic        accept;

    always_comb begin
        ea = bus.req_base + {{16{bus.req_offset[15]}}, bus.req_offset};
`ifdef LSU_ADDR_CHECK_EN
        addr_err = (ea[1:0] != 2'b00) || (ea[31:12] != '0);
`else
        addr_err = 1'b0;
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and outputs; all outputs decode from state so reset
    // drives them to their idle values without waiting for a clock edge.
    always_comb begin
        state_nx       = state;
        accept         = 1'b0;
        busy           = 1'b1;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_data  = '0;
        bus.resp_err   = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;

        case (state)
            IDLE: begin
                busy          = 1'b0;
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    accept   = 1'b1;
                    state_nx = addr_err ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                bus.mem_addr  = addr_q;
                bus.mem_read  = ~we_q;
                bus.mem_write = we_q;
                bus.mem_wdata = we_q ? wdata_q : '0;
                state_nx      = we_q ? RESP : WAIT;
            end
            WAIT: begin
                state_nx = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_data  = rdata_q;
                bus.resp_err   = err_q;
                if (bus.resp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Transaction registers: loaded only on acceptance, so requests seen
    // while busy leave them untouched. rdata_q is cleared on acceptance so
    // stores and errors respond with zero data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            we_q    <= bus.req_we;
            addr_q  <= ea[11:2];
            wdata_q <= bus.req_wdata;
            rdata_q <= '0;
            err_q   <= addr_err;
        end else if (state == WAIT) begin
            rdata_q <= bus.mem_rdata;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    load_store_unit_if bus();

    load_store_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Data memory device with registered read
    logic [31:0] dev_mem [0:1023];
    always @(posedge clk) begin
        if (bus.mem_write) dev_mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_read)  bus.mem_rdata <= dev_mem[bus.mem_addr];
    end

    // Reference view of memory contents
    logic [31:0] ref_mem [0:1023];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] calc_ea(input logic [31:0] base, input logic [15:0] off);
        int signed soff;
        soff = $signed(off);
        return base + 32'(soff);
    endfunction

    function automatic logic is_err(input logic [31:0] ea);
`ifdef LSU_ADDR_CHECK_EN
        return (ea % 4 != 0) || (ea >= 32'd4096);
`else
        return 1'b0;
`endif
    endfunction

    task automatic drive_junk();
        bus.req_we     = 1'($urandom);
        bus.req_base   = $urandom;
        bus.req_offset = 16'($urandom);
        bus.req_wdata  = $urandom;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".req_ready"},  32'(bus.req_ready),  32'd1);
        chk({tag, ".resp_valid"}, 32'(bus.resp_valid), 32'd0);
        chk({tag, ".resp_data"},  bus.resp_data,       32'd0);
        chk({tag, ".resp_err"},   32'(bus.resp_err),   32'd0);
        chk({tag, ".mem_addr"},   32'(bus.mem_addr),   32'd0);
        chk({tag, ".mem_wdata"},  bus.mem_wdata,       32'd0);
        chk({tag, ".mem_read"},   32'(bus.mem_read),   32'd0);
        chk({tag, ".mem_write"},  32'(bus.mem_write),  32'd0);
        chk({tag, ".busy"},       32'(busy),           32'd0);
    endtask

    task automatic txn(input logic we, input logic [31:0] base, input logic [15:0] off,
                       input logic [31:0] wdata, input int unsigned hold, input string tag);
        logic [31:0] ea;
        logic        err;
        logic [31:0] exp_data;
        int          exp_lat;
        int          lat;
        int          strobes;

        ea       = calc_ea(base, off);
        err      = is_err(ea);
        exp_data = (err || we) ? 32'd0 : ref_mem[ea / 4 % 1024];
        exp_lat  = err ? 1 : (we ? 2 : 3);

        @(negedge clk);
        bus.req_we     = we;
        bus.req_base   = base;
        bus.req_offset = off;
        bus.req_wdata  = wdata;
        bus.req_valid  = 1'b1;
        bus.resp_ready = 1'b0;
        chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);

        @(posedge clk);
        #1;
        bus.req_valid = 1'($urandom);
        drive_junk();

        lat = 0;
        strobes = 0;
        while (lat < 8) begin
            @(negedge clk);
            lat++;
            if (bus.mem_read || bus.mem_write) begin
                strobes++;
                chk({tag, ".mem_addr"},  32'(bus.mem_addr),  (ea / 4) % 1024);
                chk({tag, ".mem_write"}, 32'(bus.mem_write), 32'(we));
                chk({tag, ".mem_read"},  32'(bus.mem_read),  32'(!we));
                chk({tag, ".mem_wdata"}, bus.mem_wdata,      we ? wdata : 32'd0);
            end
            if (bus.resp_valid) break;
            bus.req_valid = 1'($urandom);
            drive_junk();
        end
        chk({tag, ".latency"},   32'(lat),            32'(exp_lat));
        chk({tag, ".resp_valid"},32'(bus.resp_valid), 32'd1);
        chk({tag, ".resp_data"}, bus.resp_data,       exp_data);
        chk({tag, ".resp_err"},  32'(bus.resp_err),   32'(err));

        for (int unsigned i = 0; i < hold; i++) begin
            bus.req_valid = 1'($urandom);
            drive_junk();
            @(negedge clk);
            chk({tag, ".hold_valid"}, 32'(bus.resp_valid), 32'd1);
            chk({tag, ".hold_data"},  bus.resp_data,       exp_data);
            chk({tag, ".hold_err"},   32'(bus.resp_err),   32'(err));
            chk({tag, ".hold_ready"}, 32'(bus.req_ready),  32'd0);
            chk({tag, ".hold_strb"},  32'(bus.mem_read | bus.mem_write), 32'd0);
        end

        // Handshake edge with a request pending: it must not be taken.
        bus.resp_ready = 1'b1;
        bus.req_valid  = 1'b1;
        drive_junk();
        @(negedge clk);
        chk({tag, ".post_valid"}, 32'(bus.resp_valid), 32'd0);
        chk({tag, ".post_busy"},  32'(busy),           32'd0);
        chk({tag, ".post_ready"}, 32'(bus.req_ready),  32'd1);
        chk({tag, ".strobes"},    32'(strobes),        err ? 32'd0 : 32'd1);
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b0;

        if (we && !err) ref_mem[ea / 4 % 1024] = wdata;
    endtask

    initial begin
        logic        rwe;
        logic [31:0] rbase;
        logic [15:0] roff;

        for (int i = 0; i < 1024; i++) begin
            dev_mem[i] = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
            ref_mem[i] = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b0;
        drive_junk();
        bus.req_valid  = 1'b0;

        #1;
        check_reset_outputs("reset_in");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset_out");

        txn(1'b1, 32'h0000_0100, 16'h0004, 32'hDEAD_BEEF, 0, "store_0x104");
        txn(1'b0, 32'h0000_0108, 16'hFFFC, 32'h0,         5, "load_0x104");
        txn(1'b0, 32'h0000_0100, 16'h0002, 32'h0,         0, "load_0x102");
        txn(1'b0, 32'h0000_1000, 16'h0000, 32'h0,         2, "load_0x1000");
        txn(1'b1, 32'h0000_0FFC, 16'h0008, 32'h1234_5678, 0, "store_0x1004");
        txn(1'b1, 32'h0000_0FFC, 16'h0000, 32'hCAFE_F00D, 0, "store_top");
        txn(1'b0, 32'h0000_0000, 16'h0FFC, 32'h0,         1, "load_top");

        for (int n = 0; n < 40; n++) begin
            rwe   = 1'($urandom);
            rbase = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h0000_0FFF);
            roff  = 16'($urandom_range(0, 511)) - 16'd256;
            if ($urandom_range(0, 3) != 0) begin
                rbase = rbase & ~32'd3;
                roff  = roff & ~16'd3;
            end
            txn(rwe, rbase, roff, $urandom, $urandom_range(0, 3), "rand");
        end

        // Reset while a load sits in WAIT
        @(negedge clk);
        bus.req_we     = 1'b0;
        bus.req_base   = 32'h0000_0200;
        bus.req_offset = 16'h0000;
        bus.req_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("rst_wait.busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_wait");
        @(negedge clk);
        rst_n = 1'b1;
        bus.resp_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("rst_wait.no_resp", 32'(bus.resp_valid), 32'd0);
        end
        bus.resp_ready = 1'b0;
        txn(1'b0, 32'h0000_0100, 16'h0004, 32'h0, 1, "after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
